// File: rtl/spi_boot_pkg.sv
// Shared definitions for the SPI boot master.
// Holds the frame FSM state encoding, the field widths of a frame, and the
// default command bytes understood by the SoC SPI slave port.
package spi_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_HOLD
    } state_e;

    localparam int CMD_W   = 8;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;

    localparam logic [CMD_W-1:0] DEF_WR_CMD = 8'h02;
    localparam logic [CMD_W-1:0] DEF_RD_CMD = 8'h0B;

endpackage

// File: rtl/spi_boot_clkgen.sv
// SCLK generator for the SPI boot master.
// A half-period counter runs while i_en is high; every CLK_DIV cycles it
// emits o_tick. When i_gate is also high the tick toggles SCLK, and the
// tick that is about to raise / lower SCLK is flagged on o_rise / o_fall.
// With i_gate low the counter still measures half-periods (used for the
// chip-select setup and hold phases) while SCLK stays put.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   i_en       run the half-period counter; low forces SCLK low
//   i_gate     allow SCLK to toggle on ticks
//   o_sclk     registered SPI clock
//   o_tick     last cycle of a half-period
//   o_rise     SCLK goes high on the next clk edge
//   o_fall     SCLK goes low on the next clk edge
module spi_boot_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_gate,
    output logic o_sclk,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tick;

    assign w_tick = i_en && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            if (i_gate) begin
                r_sclk <= ~r_sclk;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sclk = r_sclk;
    assign o_tick = w_tick;
    assign o_rise = w_tick && i_gate && !r_sclk;
    assign o_fall = w_tick && i_gate && r_sclk;

endmodule

// File: rtl/spi_boot_master.sv
// Single-lane SPI initiator (mode 0) for loading and debugging the SoC
// through its SPI slave port. A 32-bit read/write request accepted on the
// valid/ready interface becomes one chip-select frame:
//   write: cmd(8) addr(32) wdata(32)
//   read : cmd(8) addr(32) DUMMY_CYCLES zeros, then 32 bits sampled on MISO
// Completion is reported by a one-cycle rsp_valid pulse in the cycle CSn
// returns high; rsp_rdata holds the read data (0 after a write).
// Ports:
//   clk, rst                     system clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready = idle)
//   req_we, req_addr, req_wdata  request contents, sampled at acceptance
//   rsp_valid, rsp_rdata         completion pulse and read data
//   spi_sclk_o, spi_csn_o        SPI clock and active-low chip select
//   spi_mosi_o, spi_miso_i       SPI data out / in
module spi_boot_master
    import spi_boot_pkg::*;
#(
    parameter int         CLK_DIV      = 4,
    parameter int         DUMMY_CYCLES = 32,
    parameter logic [7:0] WR_CMD       = DEF_WR_CMD,
    parameter logic [7:0] RD_CMD       = DEF_RD_CMD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_sclk_o,
    output logic        spi_csn_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int MAX_FIELD  = (DUMMY_CYCLES > ADDR_W) ? DUMMY_CYCLES : ADDR_W;
    localparam int BIT_CNT_W  = $clog2(MAX_FIELD);
    localparam int DUMMY_LAST = (DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0;

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_csn;
    logic                   r_we;
    logic [FRAME_W-1:0]     r_shift;
    logic [DATA_W-1:0]      r_rx;
    logic                   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;

    logic w_accept;
    logic w_clk_en;
    logic w_clk_gate;
    logic w_sclk;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_field_end;

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    // Kept out of the FSM process: the clkgen strobes depend on these, and
    // the FSM depends on the strobes.
    assign w_clk_en    = (r_state != ST_IDLE);
    assign w_clk_gate  = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                         (r_state == ST_DUMMY) || (r_state == ST_DATA);
    // A field ends on the falling SCLK edge that closes its last bit.
    assign w_field_end = w_fall && (r_bit_cnt == '0);

    spi_boot_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_clk_en),
        .i_gate (w_clk_gate),
        .o_sclk (w_sclk),
        .o_tick (w_tick),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // CSn is registered from the next state so it cannot glitch while the
    // state encoding changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_csn   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_csn   <= (w_state_next == ST_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)    w_state_next = ST_SETUP;
            ST_SETUP: if (w_tick)      w_state_next = ST_CMD;
            ST_CMD:   if (w_field_end) w_state_next = ST_ADDR;
            ST_ADDR: begin
                if (w_field_end) begin
                    w_state_next = (!r_we && DUMMY_CYCLES > 0) ? ST_DUMMY : ST_DATA;
                end
            end
            ST_DUMMY: if (w_field_end) w_state_next = ST_DATA;
            ST_DATA:  if (w_field_end) w_state_next = ST_HOLD;
            ST_HOLD:  if (w_tick)      w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Bit counter: holds (bits remaining - 1) in the current field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (w_state_next != r_state) begin
            case (w_state_next)
                ST_CMD:   r_bit_cnt <= BIT_CNT_W'(CMD_W - 1);
                ST_ADDR:  r_bit_cnt <= BIT_CNT_W'(ADDR_W - 1);
                ST_DUMMY: r_bit_cnt <= BIT_CNT_W'(DUMMY_LAST);
                ST_DATA:  r_bit_cnt <= BIT_CNT_W'(DATA_W - 1);
                default:  r_bit_cnt <= '0;
            endcase
        end else if (w_fall) begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    // Reads load zeros behind the address, so shifting out after the prefix
    // naturally yields MOSI = 0 during the dummy and data phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_shift     <= '0;
            r_rx        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_we    <= req_we;
                r_shift <= {(req_we ? WR_CMD : RD_CMD), req_addr,
                            (req_we ? req_wdata : {DATA_W{1'b0}})};
            end else if (w_fall) begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end
            if (w_rise && (r_state == ST_DATA) && !r_we) begin
                r_rx <= {r_rx[DATA_W-2:0], spi_miso_i};
            end
            if ((r_state == ST_HOLD) && w_tick) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_we ? {DATA_W{1'b0}} : r_rx;
            end
        end
    end

    assign req_ready  = r_csn;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign spi_sclk_o = w_sclk;
    assign spi_csn_o  = r_csn;
    assign spi_mosi_o = r_shift[FRAME_W-1];

endmodule

// File: tb/tb_spi_boot_master.sv
// Bench for spi_boot_master: two instances (CLK_DIV=2/DUMMY=32 and
// CLK_DIV=1/DUMMY=0) are driven with fixed and random requests. A per-
// instance monitor acts as the SPI slave, records each frame, and counts
// protocol violations; frames are compared against values computed from
// the request (frame length, CSn low time, MOSI fields, response data).
module tb_spi_boot_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cd_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int dum_of(input int k);
        return (k == 0) ? 32 : 0;
    endfunction

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        sclk      [2];
    logic        csn       [2];
    logic        mosi      [2];
    logic        miso      [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            spi_boot_master #(
                .CLK_DIV      (cd_of(gi)),
                .DUMMY_CYCLES (dum_of(gi)),
                .WR_CMD       (8'h02),
                .RD_CMD       (8'h0B)
            ) u_dut (
                .clk        (clk),
                .rst        (rst[gi]),
                .req_valid  (req_valid[gi]),
                .req_ready  (req_ready[gi]),
                .req_we     (req_we[gi]),
                .req_addr   (req_addr[gi]),
                .req_wdata  (req_wdata[gi]),
                .rsp_valid  (rsp_valid[gi]),
                .rsp_rdata  (rsp_rdata[gi]),
                .spi_sclk_o (sclk[gi]),
                .spi_csn_o  (csn[gi]),
                .spi_mosi_o (mosi[gi]),
                .spi_miso_i (miso[gi])
            );
        end
    endgenerate

    // Monitor / slave bookkeeping, one entry per instance.
    int           frame_cnt [2];
    int           rsp_cnt   [2];
    int           viol      [2];
    int           cur_rises [2];
    int           rec_low   [2];
    int           rec_rises [2];
    int           rec_gap   [2];
    logic [255:0] rec_vec   [2];
    logic [31:0]  rec_rdata [2];
    logic [31:0]  slave_data[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Samples every falling clk edge: records frames, drives MISO like a
    // mode-0 slave (changes only while SCLK is low) and counts violations.
    task automatic monitor(input int k);
        logic         p_csn  = 1'b1;
        logic         p_sclk = 1'b0;
        logic         p_mosi = 1'b0;
        int           low    = 0;
        int           rises  = 0;
        int           gap    = 0;
        int           idx;
        logic [255:0] vec    = '0;
        forever begin
            @(negedge clk);
            if (rst[k]) begin
                if (rsp_valid[k]) viol[k]++;
                low = 0; rises = 0; vec = '0; cur_rises[k] = 0;
                p_csn = csn[k]; p_sclk = sclk[k]; p_mosi = mosi[k];
                continue;
            end
            if (req_ready[k] !== csn[k]) viol[k]++;
            if ((csn[k] != p_csn) && (sclk[k] || p_sclk)) viol[k]++;
            if (csn[k] && sclk[k]) viol[k]++;
            if (sclk[k] && (mosi[k] != p_mosi)) viol[k]++;
            if (rsp_valid[k]) rsp_cnt[k]++;
            if (!csn[k]) begin
                if (p_csn) begin
                    rec_gap[k] = gap;
                    gap = 0;
                end
                low++;
                if (sclk[k] && !p_sclk) begin
                    rises++;
                    vec = {vec[254:0], mosi[k]};
                end
                cur_rises[k] = rises;
            end else begin
                gap++;
                if (!p_csn) begin
                    if (!rsp_valid[k]) viol[k]++;
                    rec_low[k]   = low;
                    rec_rises[k] = rises;
                    rec_vec[k]   = vec;
                    rec_rdata[k] = rsp_rdata[k];
                    frame_cnt[k]++;
                    low = 0; rises = 0; vec = '0;
                end else if (rsp_valid[k]) begin
                    viol[k]++;
                end
            end
            if (!sclk[k]) begin
                idx = rises - 40 - dum_of(k);
                if (!csn[k] && idx >= 0 && idx < 32) miso[k] = slave_data[k][31 - idx];
                else miso[k] = 1'($urandom);
            end
            p_csn = csn[k]; p_sclk = sclk[k]; p_mosi = mosi[k];
        end
    endtask

    task automatic wait_ready(input int k);
        for (int t = 0; t < 2000 && !req_ready[k]; t++) @(negedge clk);
    endtask

    task automatic wait_frame(input int k, input int target, input string tag);
        for (int t = 0; t < 5000 && frame_cnt[k] < target; t++) @(negedge clk);
        check_val({tag, "_done"}, 64'(frame_cnt[k]), 64'(target));
    endtask

    // Expected values come straight from the frame format: N bits, CSn low
    // for (2N+2)*CLK_DIV cycles, cmd/addr first, then wdata or dummy zeros.
    task automatic check_frame(input int k, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] sdata,
                               input string tag, input int rc_exp);
        int           n;
        logic [255:0] v;
        logic [255:0] s;
        n = we ? 72 : 72 + dum_of(k);
        check_val({tag, "_rises"}, 64'(rec_rises[k]), 64'(n));
        check_val({tag, "_csn_low"}, 64'(rec_low[k]), 64'((2 * n + 2) * cd_of(k)));
        v = rec_vec[k];
        s = v >> (n - 40);
        check_val({tag, "_cmd"}, 64'(s[39:32]), we ? 64'h02 : 64'h0B);
        check_val({tag, "_addr"}, 64'(s[31:0]), 64'(addr));
        if (we) begin
            check_val({tag, "_wdata"}, 64'(v[31:0]), 64'(wdata));
        end else if (dum_of(k) > 0) begin
            s = (v >> 32) & ((256'd1 << dum_of(k)) - 256'd1);
            check_val({tag, "_dummy"}, s[63:0], 64'h0);
        end
        check_val({tag, "_rsp_cnt"}, 64'(rsp_cnt[k]), 64'(rc_exp));
        check_val({tag, "_rdata"}, 64'(rec_rdata[k]), we ? 64'h0 : 64'(sdata));
        $display("txn inst%0d %-12s %s addr=0x%08h wdata=0x%08h rdata=0x%08h", k, tag,
                 we ? "WR" : "RD", addr, wdata, rec_rdata[k]);
    endtask

    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] sdata,
                          input string tag);
        int fc0;
        int rc0;
        slave_data[k] = sdata;
        fc0 = frame_cnt[k];
        rc0 = rsp_cnt[k];
        wait_ready(k);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
        @(negedge clk);
        check_val({tag, "_busy"}, 64'(req_ready[k]), 64'h0);
        // Scramble the idle bus: only the accepted values may matter.
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        wait_frame(k, fc0 + 1, tag);
        check_frame(k, we, addr, wdata, sdata, tag, rc0 + 1);
    endtask

    task automatic back_to_back(input int k);
        int          fc0;
        int          rc0;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] sd;
        wa = $urandom; wd = $urandom; ra = $urandom; sd = $urandom;
        slave_data[k] = sd;
        fc0 = frame_cnt[k];
        rc0 = rsp_cnt[k];
        wait_ready(k);
        req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = wa; req_wdata[k] = wd;
        @(negedge clk);
        check_val("b2b_busy1", 64'(req_ready[k]), 64'h0);
        req_we[k] = 1'b0; req_addr[k] = ra; req_wdata[k] = $urandom;
        wait_frame(k, fc0 + 1, "b2b_wr");
        for (int t = 0; t < 10 && req_ready[k]; t++) @(negedge clk);
        check_val("b2b_busy2", 64'(req_ready[k]), 64'h0);
        req_valid[k] = 1'b0;
        check_frame(k, 1'b1, wa, wd, sd, "b2b_wr", rc0 + 1);
        wait_frame(k, fc0 + 2, "b2b_rd");
        check_frame(k, 1'b0, ra, 32'h0, sd, "b2b_rd", rc0 + 2);
        check_val("b2b_csn_gap", 64'(rec_gap[k]), 64'h1);
    endtask

    task automatic reset_mid_frame();
        int fc0;
        int rc0;
        slave_data[0] = $urandom;
        fc0 = frame_cnt[0];
        rc0 = rsp_cnt[0];
        wait_ready(0);
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0] = 32'h0000_4000; req_wdata[0] = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int t = 0; t < 2000 && cur_rises[0] < 40; t++) @(negedge clk);
        check_val("rst_bit40", 64'(cur_rises[0]), 64'd40);
        check_val("rst_pre_sclk", 64'(sclk[0]), 64'h1);
        #2 rst[0] = 1'b1;
        #1;
        check_val("rst_csn", 64'(csn[0]), 64'h1);
        check_val("rst_sclk", 64'(sclk[0]), 64'h0);
        check_val("rst_ready", 64'(req_ready[0]), 64'h1);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        repeat (50) @(negedge clk);
        check_val("rst_no_frame", 64'(frame_cnt[0]), 64'(fc0));
        check_val("rst_no_rsp", 64'(rsp_cnt[0]), 64'(rc0));
        $display("txn inst0 rst_abort   WR addr=0x00004000 aborted at bit 40");
        do_req(0, 1'b0, 32'h0000_4000, 32'h0, $urandom, "post_rst_rd");
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; miso[k] = 1'b0;
            frame_cnt[k] = 0; rsp_cnt[k] = 0; viol[k] = 0; cur_rises[k] = 0;
            rec_low[k] = 0; rec_rises[k] = 0; rec_gap[k] = 0;
            rec_vec[k] = '0; rec_rdata[k] = '0; slave_data[k] = '0;
        end
        fork
            monitor(0);
            monitor(1);
        join_none

        #2;
        for (int k = 0; k < 2; k++) begin
            check_val("rst_req_ready", 64'(req_ready[k]), 64'h1);
            check_val("rst_rsp_valid", 64'(rsp_valid[k]), 64'h0);
            check_val("rst_rsp_rdata", 64'(rsp_rdata[k]), 64'h0);
            check_val("rst_sclk0", 64'(sclk[k]), 64'h0);
            check_val("rst_csn1", 64'(csn[k]), 64'h1);
            check_val("rst_mosi0", 64'(mosi[k]), 64'h0);
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        do_req(0, 1'b1, 32'h0010_0000, 32'hDEAD_BEEF, $urandom, "wr_fixed");
        do_req(0, 1'b0, 32'h0000_0080, $urandom, 32'h1234_5678, "rd_fixed");
        do_req(1, 1'b0, $urandom, $urandom, $urandom, "rd_nodummy");
        do_req(1, 1'b1, $urandom, $urandom, $urandom, "wr_div1");

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                do_req(k, 1'($urandom), $urandom, $urandom, $urandom, "rand");
            end
        end

        back_to_back(0);
        back_to_back(1);
        reset_mid_frame();

        check_val("protocol_inst0", 64'(viol[0]), 64'h0);
        check_val("protocol_inst1", 64'(viol[1]), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_boot_master.md
# spi_boot_master

Single-lane SPI initiator that drives the SoC's SPI slave port (spi_clk_i, spi_cs_i, spi_sdi0_i, spi_sdo0_o) from the FPGA/host side. It turns 32-bit read/write requests on a valid/ready interface into command, address, dummy and data SPI frames, and returns read data on a one-cycle response strobe. It sits in the FPGA wrapper beside the SoC and is used for program loading and debug memory access.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range ≥1.
- DUMMY_CYCLES, 32: idle SCLK cycles between address and read data; 0 is legal.
- WR_CMD, 8'h02: command byte for writes.
- RD_CMD, 8'h0B: command byte for reads.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; a request is accepted when valid&ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  target address.
- req_wdata  in  32  write data, ignored for reads.
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  32  read data; 0 after writes; held until the next rsp_valid.
- spi_sclk_o  out  1  to SoC spi_clk_i.
- spi_csn_o  out  1  to SoC spi_cs_i, active low.
- spi_mosi_o  out  1  to SoC spi_sdi0_i.
- spi_miso_i  in  1  from SoC spi_sdo0_o.

## Operation
- SPI mode 0: SCLK idles low. MOSI changes only while SCLK is low. MISO is sampled on the rising SCLK edge. All fields go MSB first.
- Frame fields:
  - Write: 8-bit command, 32-bit address, 32-bit data; N = 72 bits.
  - Read: 8-bit command, 32-bit address, DUMMY_CYCLES dummy bits (MOSI = 0), 32-bit data; N = 72 + DUMMY_CYCLES.
- FSM states and transitions:
  - IDLE → SETUP on accept.
  - SETUP → CMD → ADDR.
  - ADDR → DUMMY for reads with DUMMY_CYCLES > 0, otherwise ADDR → DATA.
  - DUMMY → DATA.
  - DATA → HOLD → IDLE.
  - The per-state bit counter reloads at each field boundary.
- Accept: latch we, addr and wdata into a 72-bit shift register; the 40-bit command+address prefix is also used for reads.
- SETUP: CSn goes low, MOSI presents the command MSB, SCLK stays low.
- Each bit lasts 2·CLK_DIV cycles: CLK_DIV cycles low, then CLK_DIV cycles high.
  - MOSI advances on the high→low transition.
  - On reads, MISO is shifted into rsp_rdata on the low→high transition during DATA only.
- HOLD: SCLK low, CSn stays low; CSn then returns high in the first IDLE cycle.
- MISO is ignored outside DATA; writes never update the read shifter.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, spi_sclk_o=0, spi_csn_o=1, spi_mosi_o=0. All registers are reset asynchronously.
- req_ready drops the cycle after acceptance and is 0 until CSn is high again.
- spi_csn_o falls one cycle after acceptance and stays low for exactly (2N+2)·CLK_DIV cycles. This comprises CLK_DIV setup, N bits, and CLK_DIV hold.
- rsp_valid pulses in the cycle CSn rises. req_ready returns in that same cycle, so back-to-back requests give CSn a minimum high time of 1 cycle.
- Exactly N rising SCLK edges occur per frame. No SCLK activity occurs while CSn is high.
- Reset mid-frame: CSn high and SCLK low immediately (asynchronous), no rsp_valid, request discarded.
- req_valid held while busy has no effect; inputs are sampled only at acceptance.

## Structure
- Package spi_boot_pkg holds:
  - the FSM state enum;
  - field widths (CMD_W=8, ADDR_W=32, DATA_W=32);
  - default command constants.
- Sub-module spi_boot_clkgen: half-period counter with enable. It outputs sclk, a rise strobe and a fall strobe, and stays low when disabled.

## Test plan
- Write, CLK_DIV=2, addr 0x0010_0000, wdata 0xDEADBEEF:
  - slave model captures 0x02, 0x00100000, 0xDEADBEEF;
  - 72 SCLK rises; CSn low 292 cycles;
  - rsp_valid once with rdata=0.
- Read, CLK_DIV=2, DUMMY_CYCLES=32, addr 0x0000_0080, slave returns 0x1234_5678:
  - MOSI 0x0B, 0x00000080, then 32 zeros;
  - rsp_rdata=0x12345678; CSn low 420 cycles.
- Read with DUMMY_CYCLES=0, CLK_DIV=1:
  - 72 SCLK rises; data sampled immediately after the address.
- Back-to-back: req_valid held for a write then a read:
  - CSn high exactly 1 cycle between frames;
  - req_ready low throughout each frame;
  - one rsp_valid per request.
- rst asserted at bit 40 of a write:
  - CSn=1, SCLK=0 in the same cycle;
  - no rsp_valid;
  - a fresh request afterwards completes correctly.
- Protocol check: MOSI never changes while SCLK is high; SCLK low at every CSn edge (assertion-based).
